// File: rtl/branch_resolve_bht.sv
// Branch resolution at ID/EX with a 2-bit branch history table.
// Registers the redirect on mispredict, trains the BHT, and keeps saturating perf counters.
module branch_resolve_bht #(
    parameter int unsigned ADDR_W     = 32,
    parameter int unsigned BHT_DEPTH  = 64,
    parameter int unsigned IDX_W      = 6,
    parameter logic [1:0]  CNT_INIT   = 2'b01,
    parameter int unsigned DELAY_SLOT = 1,
    parameter int unsigned PERF_W     = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] if_pc,
    output logic              if_pred_taken,
    input  logic              res_valid,
    input  logic [3:0]        res_type,
    input  logic [ADDR_W-1:0] res_pc,
    input  logic [ADDR_W-1:0] res_imme,
    input  logic [ADDR_W-1:0] rdata_a,
    input  logic [ADDR_W-1:0] rdata_b,
    input  logic              res_pred_taken,
    input  logic [ADDR_W-1:0] res_pred_target,
    input  logic              stall,
    input  logic              flush,
    output logic              redirect_valid,
    output logic [ADDR_W-1:0] redirect_pc,
    output logic              actual_taken,
    output logic [PERF_W-1:0] branch_cnt,
    output logic [PERF_W-1:0] mispred_cnt
);

    localparam logic [3:0] T_BEQ  = 4'd1;
    localparam logic [3:0] T_BNE  = 4'd2;
    localparam logic [3:0] T_BGTZ = 4'd3;
    localparam logic [3:0] T_BLEZ = 4'd4;
    localparam logic [3:0] T_BLTZ = 4'd5;
    localparam logic [3:0] T_BGEZ = 4'd6;
    localparam logic [3:0] T_J    = 4'd7;
    localparam logic [3:0] T_JR   = 4'd8;
    localparam int unsigned FALL_OFS = (DELAY_SLOT != 0) ? 8 : 4;

    logic [1:0]        bht_q [BHT_DEPTH];
    logic              redirect_valid_q, redirect_valid_d;
    logic [ADDR_W-1:0] redirect_pc_q, redirect_pc_d;
    logic              actual_taken_q, actual_taken_d;
    logic [PERF_W-1:0] branch_cnt_q, branch_cnt_d;
    logic [PERF_W-1:0] mispred_cnt_q, mispred_cnt_d;

    logic [ADDR_W-1:0] pc4, br_tgt, j_tgt, fall, target;
    logic              a_zero, a_neg, taken, is_cond, is_branch, accept, mispredict;
    logic [IDX_W-1:0]  res_idx, if_idx;
    logic [1:0]        cnt_cur, cnt_nxt;
    logic              bht_we;
    logic              unused_bits;

    assign if_idx        = if_pc[IDX_W+1:2];
    assign res_idx       = res_pc[IDX_W+1:2];
    assign if_pred_taken = bht_q[if_idx][1];
    assign unused_bits   = ^{if_pc[1:0], if_pc[ADDR_W-1:IDX_W+2], res_imme[ADDR_W-1:26]};

    // Resolve direction and target of the presented instruction.
    always_comb begin
        pc4        = res_pc + ADDR_W'(4);
        br_tgt     = pc4 + {{(ADDR_W-18){res_imme[15]}}, res_imme[15:0], 2'b00};
        j_tgt      = {pc4[ADDR_W-1:28], res_imme[25:0], 2'b00};
        fall       = res_pc + ADDR_W'(FALL_OFS);
        a_zero     = (rdata_a == '0);
        a_neg      = rdata_a[ADDR_W-1];
        taken      = 1'b0;
        is_cond    = 1'b0;
        is_branch  = 1'b1;
        target     = br_tgt;
        case (res_type)
            T_BEQ:  begin is_cond = 1'b1; taken = (rdata_a == rdata_b); end
            T_BNE:  begin is_cond = 1'b1; taken = (rdata_a != rdata_b); end
            T_BGTZ: begin is_cond = 1'b1; taken = !a_neg && !a_zero; end
            T_BLEZ: begin is_cond = 1'b1; taken = a_neg || a_zero; end
            T_BLTZ: begin is_cond = 1'b1; taken = a_neg; end
            T_BGEZ: begin is_cond = 1'b1; taken = !a_neg; end
            T_J:    begin taken = 1'b1; target = j_tgt; end
            T_JR:   begin taken = 1'b1; target = rdata_a; end
            default: is_branch = 1'b0;
        endcase
        accept     = res_valid && !stall && !flush && is_branch;
        mispredict = (taken != res_pred_taken) || (taken && (res_pred_target != target));
    end

    // Counter training and next-state for the registered outputs.
    always_comb begin
        cnt_cur          = bht_q[res_idx];
        cnt_nxt          = cnt_cur;
        bht_we           = accept && is_cond;
        redirect_valid_d = redirect_valid_q;
        redirect_pc_d    = redirect_pc_q;
        actual_taken_d   = actual_taken_q;
        branch_cnt_d     = branch_cnt_q;
        mispred_cnt_d    = mispred_cnt_q;
        if (taken) begin
            if (cnt_cur != 2'b11) cnt_nxt = cnt_cur + 2'd1;
        end else begin
            if (cnt_cur != 2'b00) cnt_nxt = cnt_cur - 2'd1;
        end
        if (!stall) begin
            redirect_valid_d = 1'b0;
            if (accept) begin
                redirect_valid_d = mispredict;
                redirect_pc_d    = taken ? target : fall;
                actual_taken_d   = taken;
                if (!(&branch_cnt_q)) branch_cnt_d = branch_cnt_q + PERF_W'(1);
                if (mispredict && !(&mispred_cnt_q)) mispred_cnt_d = mispred_cnt_q + PERF_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            redirect_valid_q <= 1'b0;
            redirect_pc_q    <= '0;
            actual_taken_q   <= 1'b0;
            branch_cnt_q     <= '0;
            mispred_cnt_q    <= '0;
            for (int i = 0; i < int'(BHT_DEPTH); i++) bht_q[i] <= CNT_INIT;
        end else begin
            redirect_valid_q <= redirect_valid_d;
            redirect_pc_q    <= redirect_pc_d;
            actual_taken_q   <= actual_taken_d;
            branch_cnt_q     <= branch_cnt_d;
            mispred_cnt_q    <= mispred_cnt_d;
            if (bht_we) bht_q[res_idx] <= cnt_nxt;
        end
    end

    assign redirect_valid = redirect_valid_q;
    assign redirect_pc    = redirect_pc_q;
    assign actual_taken   = actual_taken_q;
    assign branch_cnt     = branch_cnt_q;
    assign mispred_cnt    = mispred_cnt_q;

endmodule

// File: tb/tb_branch_resolve_bht.sv
// Directed bench for branch_resolve_bht: vector table plus multi-cycle corner sequences.
module tb_branch_resolve_bht;

    typedef struct {
        logic [3:0]  typ;
        logic [31:0] pc, imm, a, b;
        logic        pt;
        logic [31:0] ptgt;
        logic        exp_tk, exp_rv;
        logic [31:0] exp_rpc;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] if_pc;
    logic        if_pred_taken;
    logic        res_valid;
    logic [3:0]  res_type;
    logic [31:0] res_pc, res_imme, rdata_a, rdata_b, res_pred_target;
    logic        res_pred_taken, stall, flush;
    logic        redirect_valid, actual_taken;
    logic [31:0] redirect_pc, branch_cnt, mispred_cnt;

    logic        sat_pred, sat_rv, sat_at;
    logic [31:0] sat_rpc;
    logic [1:0]  sat_bcnt, sat_mcnt;

    int          n_chk = 0;
    int          n_fail = 0;
    int          exp_br, exp_mis;
    logic [1:0]  bht_m [64];
    vec_t        vecs [14];

    always #5 clk = ~clk;

    branch_resolve_bht u_dut (
        .clk(clk), .rst(rst), .if_pc(if_pc), .if_pred_taken(if_pred_taken),
        .res_valid(res_valid), .res_type(res_type), .res_pc(res_pc), .res_imme(res_imme),
        .rdata_a(rdata_a), .rdata_b(rdata_b), .res_pred_taken(res_pred_taken),
        .res_pred_target(res_pred_target), .stall(stall), .flush(flush),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .actual_taken(actual_taken),
        .branch_cnt(branch_cnt), .mispred_cnt(mispred_cnt)
    );

    // Narrow-counter instance so saturation is reachable in a few cycles.
    branch_resolve_bht #(.PERF_W(2)) u_sat (
        .clk(clk), .rst(rst), .if_pc(if_pc), .if_pred_taken(sat_pred),
        .res_valid(res_valid), .res_type(res_type), .res_pc(res_pc), .res_imme(res_imme),
        .rdata_a(rdata_a), .rdata_b(rdata_b), .res_pred_taken(res_pred_taken),
        .res_pred_target(res_pred_target), .stall(stall), .flush(flush),
        .redirect_valid(sat_rv), .redirect_pc(sat_rpc), .actual_taken(sat_at),
        .branch_cnt(sat_bcnt), .mispred_cnt(sat_mcnt)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic [3:0] typ, input logic [31:0] pc, input logic [31:0] imm,
                                input logic [31:0] a, input logic [31:0] b, input logic pt,
                                input logic [31:0] ptgt, input logic tk, input logic rv,
                                input logic [31:0] rpc);
        vec_t v;
        v.typ = typ; v.pc = pc; v.imm = imm; v.a = a; v.b = b; v.pt = pt; v.ptgt = ptgt;
        v.exp_tk = tk; v.exp_rv = rv; v.exp_rpc = rpc;
        return v;
    endfunction

    task automatic drive(input vec_t v);
        res_valid = 1'b1; res_type = v.typ; res_pc = v.pc; res_imme = v.imm;
        rdata_a = v.a; rdata_b = v.b; res_pred_taken = v.pt; res_pred_target = v.ptgt;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1; res_valid = 1'b0; stall = 1'b0; flush = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        exp_br = 0; exp_mis = 0;
        for (int i = 0; i < 64; i++) bht_m[i] = 2'b01;
    endtask

    task automatic check_regs(input string tag, input logic rv, input logic [31:0] rpc, input logic tk);
        chk({tag, ".redirect_valid"}, 32'(redirect_valid), 32'(rv));
        chk({tag, ".redirect_pc"}, redirect_pc, rpc);
        chk({tag, ".actual_taken"}, 32'(actual_taken), 32'(tk));
        chk({tag, ".branch_cnt"}, branch_cnt, 32'(exp_br));
        chk({tag, ".mispred_cnt"}, mispred_cnt, 32'(exp_mis));
    endtask

    task automatic check_pred(input string tag, input logic [31:0] pc);
        if_pc = pc;
        #1;
        chk({tag, ".if_pred_taken"}, 32'(if_pred_taken), 32'(bht_m[pc[7:2]][1]));
    endtask

    // One accepted resolve: drive, clock, update the model, compare.
    task automatic run_vec(input string tag, input vec_t v);
        @(negedge clk);
        stall = 1'b0; flush = 1'b0;
        drive(v);
        @(posedge clk);
        #1 res_valid = 1'b0;
        exp_br++;
        if (v.exp_rv) exp_mis++;
        if (v.typ >= 4'd1 && v.typ <= 4'd6) begin
            if (v.exp_tk && bht_m[v.pc[7:2]] != 2'b11) bht_m[v.pc[7:2]] = bht_m[v.pc[7:2]] + 2'd1;
            if (!v.exp_tk && bht_m[v.pc[7:2]] != 2'b00) bht_m[v.pc[7:2]] = bht_m[v.pc[7:2]] - 2'd1;
        end
        check_regs(tag, v.exp_rv, v.exp_rpc, v.exp_tk);
        check_pred(tag, v.pc);
    endtask

    initial begin
        vec_t v;
        string tag;
        logic [31:0] hold_rpc;
        rst = 1'b1; if_pc = 32'h100; res_valid = 1'b0; res_type = 4'd0; res_pc = '0;
        res_imme = '0; rdata_a = '0; rdata_b = '0; res_pred_taken = 1'b0;
        res_pred_target = '0; stall = 1'b0; flush = 1'b0;

        //        typ   pc            imm           a             b      pt ptgt          tk rv rpc
        vecs[0]  = mk(4'd1, 32'h400,      32'hFFFF,     32'd5,        32'd5, 0, 32'h0,        1, 1, 32'h400);
        vecs[1]  = mk(4'd2, 32'h1000,     32'h10,       32'd7,        32'd7, 0, 32'h0,        0, 0, 32'h1008);
        vecs[2]  = mk(4'd2, 32'h1000,     32'h10,       32'd7,        32'd7, 1, 32'h2000,     0, 1, 32'h1008);
        vecs[3]  = mk(4'd3, 32'h2000,     32'h10,       32'h80000000, 32'd0, 0, 32'h0,        0, 0, 32'h2008);
        vecs[4]  = mk(4'd4, 32'h2000,     32'h10,       32'h80000000, 32'd0, 0, 32'h0,        1, 1, 32'h2044);
        vecs[5]  = mk(4'd5, 32'h3000,     32'h3,        32'hFFFFFFFF, 32'd0, 1, 32'h3010,     1, 0, 32'h3010);
        vecs[6]  = mk(4'd6, 32'h3000,     32'h3,        32'hFFFFFFFF, 32'd0, 0, 32'h0,        0, 0, 32'h3008);
        vecs[7]  = mk(4'd6, 32'h3100,     32'h1,        32'd0,        32'd0, 1, 32'h3100,     1, 1, 32'h3108);
        vecs[8]  = mk(4'd7, 32'h90000000, 32'h40,       32'd0,        32'd0, 1, 32'h90000100, 1, 0, 32'h90000100);
        vecs[9]  = mk(4'd7, 32'h90000000, 32'h40,       32'd0,        32'd0, 0, 32'h0,        1, 1, 32'h90000100);
        vecs[10] = mk(4'd8, 32'h500,      32'h0,        32'h1234,     32'd0, 1, 32'h1234,     1, 0, 32'h1234);
        vecs[11] = mk(4'd8, 32'h500,      32'h0,        32'h1234,     32'd0, 1, 32'h1238,     1, 1, 32'h1234);
        vecs[12] = mk(4'd3, 32'h2000,     32'h10,       32'd1,        32'd0, 1, 32'h2044,     1, 0, 32'h2044);
        vecs[13] = mk(4'd1, 32'h600,      32'h0,        32'd1,        32'd2, 1, 32'h604,      0, 1, 32'h608);

        do_reset();
        check_regs("reset", 1'b0, 32'h0, 1'b0);
        for (int i = 0; i < 64; i++) begin
            if_pc = 32'(i) << 2;
            #1 chk($sformatf("reset.bht%0d", i), 32'(if_pred_taken), 32'd0);
        end

        for (int i = 0; i < 14; i++) run_vec($sformatf("vec%0d", i), vecs[i]);

        // Counter saturation at index 16: four taken, then two not-taken.
        for (int i = 0; i < 4; i++)
            run_vec($sformatf("sat_tk%0d", i), mk(4'd1, 32'h840, 32'h0, 32'd3, 32'd3, 1, 32'h844, 1, 0, 32'h844));
        chk("sat.bht_state", 32'(if_pred_taken), 32'd1);
        for (int i = 0; i < 2; i++)
            run_vec($sformatf("sat_nt%0d", i), mk(4'd1, 32'h840, 32'h0, 32'd3, 32'd4, 0, 32'h0, 0, 0, 32'h848));
        chk("sat.after_two_nt", 32'(if_pred_taken), 32'd0);

        // Establish a pending redirect, then stall must hold it.
        run_vec("pre_stall", vecs[13]);
        v = mk(4'd1, 32'h880, 32'h0, 32'd9, 32'd9, 0, 32'h0, 1, 1, 32'h884);
        @(negedge clk);
        drive(v); stall = 1'b1;
        @(posedge clk);
        #1 res_valid = 1'b0; stall = 1'b0;
        check_regs("stall", 1'b1, 32'h608, 1'b0);
        check_pred("stall", 32'h880);

        @(negedge clk);
        drive(v); flush = 1'b1;
        @(posedge clk);
        #1 res_valid = 1'b0; flush = 1'b0;
        check_regs("flush", 1'b0, 32'h608, 1'b0);
        check_pred("flush", 32'h880);

        @(negedge clk);
        v.typ = 4'd9; drive(v);
        @(posedge clk);
        #1 res_valid = 1'b0;
        check_regs("type9", 1'b0, 32'h608, 1'b0);

        // Same-cycle lookup of the index being trained sees the old counter.
        v.typ = 4'd1;
        @(negedge clk);
        drive(v); if_pc = 32'h880;
        #1 chk("bypass.pre", 32'(if_pred_taken), 32'd0);
        @(posedge clk);
        #1 res_valid = 1'b0;
        exp_br++; exp_mis++; bht_m[32] = 2'b10;
        chk("bypass.post", 32'(if_pred_taken), 32'd1);
        check_regs("bypass", 1'b1, 32'h884, 1'b1);

        // Reset with a valid request: no training, everything cleared.
        @(negedge clk);
        drive(v); rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0; res_valid = 1'b0;
        exp_br = 0; exp_mis = 0;
        for (int i = 0; i < 64; i++) bht_m[i] = 2'b01;
        check_regs("rst_mid", 1'b0, 32'h0, 1'b0);
        check_pred("rst_mid", 32'h880);
        chk("rst_mid.sat_bcnt", 32'(sat_bcnt), 32'd0);

        // Narrow counters must stick at all-ones.
        for (int i = 1; i <= 5; i++) begin
            tag = $sformatf("perfsat%0d", i);
            run_vec(tag, vecs[9]);
            chk({tag, ".sat_mcnt"}, 32'(sat_mcnt), (i > 3) ? 32'd3 : 32'(i));
            chk({tag, ".sat_bcnt"}, 32'(sat_bcnt), (i > 3) ? 32'd3 : 32'(i));
            chk({tag, ".sat_rv"}, 32'(sat_rv), 32'd1);
        end
        hold_rpc = sat_rpc;
        chk("perfsat.sat_rpc", hold_rpc, 32'h90000100);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
